// File: rtl/log_capture_sequencer.sv
// Log-memory capture/dump sequencer: arms a capture after a programmable delay,
// waits for memory full, then streams the whole log out over valid/ready.
// Optional capture watchdog with o_timeout port: define LOG_SEQ_TIMEOUT_EN.
module log_capture_sequencer #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int READ_LAT        = 2,
    parameter int NB_DELAY        = 16
) (
    input  logic                         clk100,
    input  logic                         i_resetn,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [NB_DELAY-1:0]          i_trig_delay,
    input  logic                         i_rd_req,
    input  logic                         i_mem_full,
    input  logic [2*BRAM_DATA_WIDTH-1:0] i_data,
    input  logic                         i_ready,
    output logic                         o_run_log,
    output logic                         o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0]   o_addr,
    output logic [2*BRAM_DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_state
`ifdef LOG_SEQ_TIMEOUT_EN
    ,
    output logic                         o_timeout
`endif
);

    localparam int LW = $clog2(READ_LAT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DELAY     = 3'd1,
        CAPTURE   = 3'd2,
        FULL      = 3'd3,
        DUMP_ADDR = 3'd4,
        DUMP_WAIT = 3'd5,
        DUMP_OUT  = 3'd6
    } state_t;

    state_t              state;
    logic [NB_DELAY-1:0] dly_cnt;
    logic [LW-1:0]       lat_cnt;
    logic                captured;
`ifdef LOG_SEQ_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000;
    logic [31:0]         wdog;
`endif

    assign o_state = state;

    always_ff @(posedge clk100) begin
        if (!i_resetn) begin
            state      <= IDLE;
            dly_cnt    <= '0;
            lat_cnt    <= '0;
            captured   <= 1'b0;
            o_run_log  <= 1'b0;
            o_read_log <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef LOG_SEQ_TIMEOUT_EN
            wdog       <= '0;
            o_timeout  <= 1'b0;
`endif
        end else begin
            o_run_log <= 1'b0;
            o_done    <= 1'b0;
`ifdef LOG_SEQ_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
            if (i_abort) begin
                // A completed capture survives an abort only while it is parked in FULL.
                state      <= IDLE;
                o_valid    <= 1'b0;
                o_read_log <= 1'b0;
                o_addr     <= '0;
                o_busy     <= 1'b0;
                if (state != FULL) captured <= 1'b0;
            end else begin
                case (state)
                    IDLE, FULL: begin
                        if (i_start) begin
                            dly_cnt  <= i_trig_delay;
                            captured <= 1'b0;
                            o_busy   <= 1'b1;
                            state    <= DELAY;
                        end else if (i_rd_req && captured) begin
                            o_busy <= 1'b1;
                            state  <= DUMP_ADDR;
                        end
                    end
                    DELAY: begin
                        if (dly_cnt == '0) begin
                            o_run_log <= 1'b1;
                            state     <= CAPTURE;
`ifdef LOG_SEQ_TIMEOUT_EN
                            wdog      <= '0;
`endif
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end
                    CAPTURE: begin
                        if (i_mem_full) begin
                            captured <= 1'b1;
                            o_busy   <= 1'b0;
                            state    <= FULL;
                        end
`ifdef LOG_SEQ_TIMEOUT_EN
                        else if (wdog == TIMEOUT_CYCLES - 1) begin
                            captured  <= 1'b0;
                            o_busy    <= 1'b0;
                            o_timeout <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            wdog <= wdog + 1'b1;
                        end
`endif
                    end
                    DUMP_ADDR: begin
                        o_addr     <= '0;
                        o_read_log <= 1'b1;
                        lat_cnt    <= LW'(READ_LAT);
                        state      <= DUMP_WAIT;
                    end
                    DUMP_WAIT: begin
                        // One extra cycle beyond READ_LAT so the word is sampled after it settles.
                        if (lat_cnt == '0) begin
                            o_data  <= i_data;
                            o_valid <= 1'b1;
                            state   <= DUMP_OUT;
                        end else begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end
                    end
                    DUMP_OUT: begin
                        if (o_valid && i_ready) begin
                            o_valid <= 1'b0;
                            if (&o_addr) begin
                                o_addr     <= '0;
                                o_read_log <= 1'b0;
                                o_done     <= 1'b1;
                                o_busy     <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                o_addr  <= o_addr + 1'b1;
                                lat_cnt <= LW'(READ_LAT);
                                state   <= DUMP_WAIT;
                            end
                        end
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_log_capture_sequencer.sv
// Directed bench for log_capture_sequencer: small 16-word log, READ_LAT=2,
// memory model returns 32'hA500_0000 | address.
module tb_log_capture_sequencer;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int ND = 16;

    logic          clk100 = 1'b0;
    logic          i_resetn, i_start, i_abort, i_rd_req, i_mem_full, i_ready;
    logic [ND-1:0] i_trig_delay;
    logic [2*DW-1:0] i_data;
    logic          o_run_log, o_read_log, o_valid, o_busy, o_done;
    logic [AW-1:0] o_addr;
    logic [2*DW-1:0] o_data;
    logic [2:0]    o_state;

    int tests  = 0;
    int failed = 0;

    log_capture_sequencer #(
        .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .READ_LAT(RL), .NB_DELAY(ND)
    ) dut (
        .clk100(clk100), .i_resetn(i_resetn), .i_start(i_start), .i_abort(i_abort),
        .i_trig_delay(i_trig_delay), .i_rd_req(i_rd_req), .i_mem_full(i_mem_full),
        .i_data(i_data), .i_ready(i_ready), .o_run_log(o_run_log), .o_read_log(o_read_log),
        .o_addr(o_addr), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
        .o_done(o_done), .o_state(o_state)
    );

    always #5 clk100 = ~clk100;

    // Memory with RL cycles of read latency.
    logic [2*DW-1:0] mem_pipe [RL];
    always @(posedge clk100) begin
        mem_pipe[0] <= 32'hA500_0000 | 32'(o_addr);
        for (int k = 1; k < RL; k++) mem_pipe[k] <= mem_pipe[k-1];
    end
    assign i_data = mem_pipe[RL-1];

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
        int k = 0;
        while (o_state !== exp && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(o_state), 32'(exp));
    endtask

    task automatic capture_to_full(input logic [ND-1:0] dly);
        i_trig_delay = dly;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_state("to_capture", 3'd2, 100);
        check("busy_capture", 32'(o_busy), 32'd1);
        i_mem_full = 1'b1;
        tick();
        i_mem_full = 1'b0;
        check("full_state", 32'(o_state), 32'd3);
        check("full_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic run_dump(input bit bp);
        int n = 0, dones = 0, first = 0, last = 0;
        bit pstall = 0;
        logic [31:0] pd = '0;
        i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        check("dump_addr_state", 32'(o_state), 32'd4);
        for (int cyc = 0; cyc < 2000 && dones == 0; cyc++) begin
            if (pstall) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_data", o_data, pd);
            end
            if (o_valid && i_ready) begin
                check("word_data", o_data, 32'hA500_0000 | 32'(n));
                check("word_addr", 32'(o_addr), 32'(n));
                check("word_readlog", 32'(o_read_log), 32'd1);
                if (n == 0) first = cyc;
                else if (!bp) check("word_spacing", 32'(cyc - last), 32'(RL + 2));
                last = cyc;
                n++;
            end
            pstall = o_valid && !i_ready;
            pd = o_data;
            tick();
            if (bp) i_ready = 1'($urandom_range(0, 1));
            if (o_done) begin
                dones++;
                check("done_readlog", 32'(o_read_log), 32'd0);
                check("done_state", 32'(o_state), 32'd0);
                check("done_addr", 32'(o_addr), 32'd0);
            end
        end
        check("xfer_count", 32'(n), 32'd16);
        check("done_count", 32'(dones), 32'd1);
        if (!bp) check("dump_span", 32'(last - first), 32'(15 * (RL + 2)));
        tick();
        check("done_single", 32'(o_done), 32'd0);
        i_ready = 1'b0;
    endtask

    initial begin
        int n;
        i_resetn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_rd_req = 1'b0;
        i_mem_full = 1'b0; i_ready = 1'b0; i_trig_delay = '0;
        tick();
        tick();
        i_resetn = 1'b1;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_outs", {25'd0, o_run_log, o_read_log, o_valid, o_busy, o_done, 2'd0}, 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_data", o_data, 32'd0);

        // Dump request and memory-full before any capture are ignored.
        i_rd_req = 1'b1; i_mem_full = 1'b1;
        tick();
        i_rd_req = 1'b0; i_mem_full = 1'b0;
        tick();
        check("rdreq_nocap_state", 32'(o_state), 32'd0);
        check("rdreq_nocap_readlog", 32'(o_read_log), 32'd0);

        // Delay 5: start in cycle 0, run pulse in cycle 7 only.
        i_trig_delay = 16'd5;
        i_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            i_start = 1'b0;
            check($sformatf("run_d5_c%0d", c), 32'(o_run_log), 32'(c == 7));
        end
        check("capture_state", 32'(o_state), 32'd2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_capture", 32'(o_state), 32'd0);

        // Delay 0: run pulse in cycle 2.
        i_trig_delay = 16'd0;
        i_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            i_start = 1'b0;
            check($sformatf("run_d0_c%0d", c), 32'(o_run_log), 32'(c == 2));
        end
        i_mem_full = 1'b1;
        tick();
        i_mem_full = 1'b0;
        check("full_after_d0", 32'(o_state), 32'd3);

        run_dump(1'b0);
        run_dump(1'b1);

        // Abort during DELAY suppresses the run pulse.
        i_trig_delay = 16'd3;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_delay_state", 32'(o_state), 32'd0);
        for (int c = 0; c < 10; c++) begin
            check("abort_delay_norun", 32'(o_run_log), 32'd0);
            tick();
        end

        // Abort after the third word; later dump request ignored.
        capture_to_full(16'd0);
        i_ready = 1'b1;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 3; c++) begin
            if (o_valid && i_ready) n++;
            tick();
        end
        check("abort_dump_words", 32'(n), 32'd3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_dump_state", 32'(o_state), 32'd0);
        check("abort_dump_flags", {29'd0, o_valid, o_read_log, o_busy}, 32'd0);
        check("abort_dump_addr", 32'(o_addr), 32'd0);
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        tick();
        check("rdreq_after_abort_state", 32'(o_state), 32'd0);
        check("rdreq_after_abort_readlog", 32'(o_read_log), 32'd0);

        // Abort in FULL keeps the capture; start then beats rd_req.
        capture_to_full(16'd2);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("abort_full_state", 32'(o_state), 32'd0);
        i_trig_delay = 16'd0;
        i_start = 1'b1; i_rd_req = 1'b1;
        tick();
        i_start = 1'b0; i_rd_req = 1'b0;
        check("prio_start_state", 32'(o_state), 32'd1);
        check("prio_readlog", 32'(o_read_log), 32'd0);

        // Synchronous reset in the middle of a dump.
        wait_state("prio_to_capture", 3'd2, 20);
        i_mem_full = 1'b1;
        tick();
        i_mem_full = 1'b0;
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("mid_dump_readlog", 32'(o_read_log), 32'd1);
        i_resetn = 1'b0;
        tick();
        i_resetn = 1'b1;
        check("rst_mid_state", 32'(o_state), 32'd0);
        check("rst_mid_flags", {29'd0, o_valid, o_read_log, o_busy}, 32'd0);
        check("rst_mid_addr", 32'(o_addr), 32'd0);
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        tick();
        check("rdreq_after_rst", 32'(o_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end
endmodule
